pointing_device_arbiter: RTL and testbench

Merges the byte streams of two emulated pointing devices, for example player 1 and player 2 spoon emulators, onto the single serial input channel of the CD-i. Each source writes into its own packet-aware FIFO. Only complete packets become visible to a round-robin arbiter, which emits them atomically, never interleaved. Output bytes are paced at the 1200-baud byte rate, so the merged stream never exceeds channel capacity; excess traffic is dropped at packet granularity.

---
 rtl/pointing_device_arbiter_if.sv | 25 ++
 rtl/pointing_device_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_pointing_device_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pointing_device_arbiter_if.sv
// Signal bundle between the two pointing-device sources, the flush control,
// and the merged serial byte channel of the arbiter.
interface pointing_device_arbiter_if;
  logic       rts;
  logic       overclock;
  logic       in0_write;
  logic [7:0] in0_data;
  logic       in1_write;
  logic [7:0] in1_data;
  logic       out_write;
  logic [7:0] out_data;
  logic       out_src;
  logic       drop0;
  logic       drop1;

  modport master (
    output rts, overclock, in0_write, in0_data, in1_write, in1_data,
    input  out_write, out_data, out_src, drop0, drop1
  );

  modport slave (
    input  rts, overclock, in0_write, in0_data, in1_write, in1_data,
    output out_write, out_data, out_src, drop0, drop1
  );
endinterface

// File: rtl/pointing_device_arbiter.sv
// Merges two pointing-device byte streams into one paced serial channel:
// per-source packet-aware FIFOs feed a round-robin, packet-atomic arbiter.
module pointing_device_arbiter #(
  parameter int FIFO_DEPTH      = 8,
  parameter int TICKS_NORMAL    = 250000,
  parameter int TICKS_OVERCLOCK = 200000
) (
  input  logic                     clk,
  input  logic                     reset,
  pointing_device_arbiter_if.slave bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;
  localparam int TMAX = (TICKS_NORMAL > TICKS_OVERCLOCK) ? TICKS_NORMAL : TICKS_OVERCLOCK;
  localparam int CW   = $clog2(TMAX) + 1;
  localparam logic [7:0] ID_BYTE = 8'hCA;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {IDLE, SEND} state_t;

  logic       in_write [2];
  logic [7:0] in_data  [2];

  assign in_write[0] = bus.in0_write;
  assign in_write[1] = bus.in1_write;
  assign in_data[0]  = bus.in0_data;
  assign in_data[1]  = bus.in1_data;

  ptr_t       wr_q     [2];
  ptr_t       wr_d     [2];
  ptr_t       commit_q [2];
  ptr_t       commit_d [2];
  ptr_t       rd_q     [2];
  logic [1:0] exp_q    [2];
  logic [1:0] exp_d    [2];
  logic       disc_q   [2];
  logic       disc_d   [2];
  logic       drop_q   [2];
  logic       drop_d   [2];
  logic       mem_we   [2];
  logic [AW-1:0] mem_wa [2];
  ptr_t       base     [2];
  ptr_t       free     [2];
  logic [1:0] pkt_len  [2];
  logic [7:0] mem      [2][FIFO_DEPTH];

  // Packet assembler: a start byte aborts any open packet by rolling wr back
  // to commit, so only whole packets ever become visible to the arbiter.
  // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wr_d[s]     = wr_q[s];
      commit_d[s] = commit_q[s];
      exp_d[s]    = exp_q[s];
      disc_d[s]   = disc_q[s];
      drop_d[s]   = 1'b0;
      mem_we[s]   = 1'b0;
      base[s]     = (exp_q[s] != 2'd0) ? commit_q[s] : wr_q[s];
      free[s]     = ptr_t'(FIFO_DEPTH) - (base[s] - rd_q[s]);
      pkt_len[s]  = (in_data[s] == ID_BYTE) ? 2'd1 : 2'd3;
      mem_wa[s]   = wr_q[s][AW-1:0];

      if (in_write[s] && !bus.rts) begin
        if (in_data[s][7:6] == 2'b11) begin
          drop_d[s] = (exp_q[s] != 2'd0);
          wr_d[s]   = base[s];
          exp_d[s]  = pkt_len[s] - 2'd1;
          if (free[s] >= ptr_t'(pkt_len[s])) begin
            mem_we[s] = 1'b1;
            mem_wa[s] = base[s][AW-1:0];
            wr_d[s]   = base[s] + ptr_t'(1);
            disc_d[s] = 1'b0;
            if (pkt_len[s] == 2'd1) commit_d[s] = base[s] + ptr_t'(1);
          end else begin
            drop_d[s] = 1'b1;
            disc_d[s] = 1'b1;
          end
        end else if (in_data[s][7]) begin
          if (exp_q[s] != 2'd0) begin
            if (!disc_q[s]) begin
              mem_we[s] = 1'b1;
              wr_d[s]   = wr_q[s] + ptr_t'(1);
            end
            exp_d[s] = exp_q[s] - 2'd1;
            if (exp_q[s] == 2'd1) begin
              if (!disc_q[s]) commit_d[s] = wr_q[s] + ptr_t'(1);
              disc_d[s] = 1'b0;
            end
          end else begin
            drop_d[s] = 1'b1;
          end
        end else begin
          drop_d[s] = 1'b1;
        end
      end
    end
  end

  // NOTE: storage has no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (mem_we[s]) mem[s][mem_wa[s]] <= in_data[s];
    end
  end

  state_t        state_q, state_d;
  logic [1:0]    rem_q, rem_d;
  logic          last_q, last_d;
  logic [CW-1:0] pace_q;
  logic          out_write_q;
  logic [7:0]    out_data_q;
  logic          out_src_q;
  logic          pend [2];
  logic          sel;
  logic          pop;
  logic [7:0]    head;

  assign pend[0] = (commit_q[0] != rd_q[0]);
  assign pend[1] = (commit_q[1] != rd_q[1]);

  // A packet in flight keeps its source; otherwise a tie goes to the source not served last.
  always_comb begin
    if (state_q == SEND)        sel = out_src_q;
    else if (pend[0] && pend[1]) sel = ~last_q;
    else                         sel = pend[1];
  end

  assign head = mem[sel][rd_q[sel][AW-1:0]];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    last_d  = last_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pace_q == '0 && (pend[0] || pend[1])) begin
          pop = 1'b1;
          if (head == ID_BYTE) begin
            last_d = sel;
          end else begin
            state_d = SEND;
            rem_d   = 2'd2;
          end
        end
      end
      SEND: begin
        if (pace_q == '0) begin
          pop   = 1'b1;
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = IDLE;
            last_d  = sel;
          end
        end
      end
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
      last_q  <= 1'b1;
    end else if (bus.rts) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wr_q[s]     <= '0;
        commit_q[s] <= '0;
        rd_q[s]     <= '0;
        exp_q[s]    <= 2'd0;
        disc_q[s]   <= 1'b0;
        drop_q[s]   <= 1'b0;
      end
      pace_q      <= '0;
      out_write_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_src_q   <= 1'b0;
    end else if (bus.rts) begin
      for (int s = 0; s < 2; s++) begin
        wr_q[s]     <= '0;
        commit_q[s] <= '0;
        rd_q[s]     <= '0;
        exp_q[s]    <= 2'd0;
        disc_q[s]   <= 1'b0;
        drop_q[s]   <= 1'b0;
      end
      pace_q      <= '0;
      out_write_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_q[s]     <= wr_d[s];
        commit_q[s] <= commit_d[s];
        exp_q[s]    <= exp_d[s];
        disc_q[s]   <= disc_d[s];
        drop_q[s]   <= drop_d[s];
        if (pop && sel == 1'(s)) rd_q[s] <= rd_q[s] + ptr_t'(1);
      end
      out_write_q <= pop;
      if (pop) begin
        out_data_q <= head;
        out_src_q  <= sel;
        pace_q     <= bus.overclock ? CW'(TICKS_OVERCLOCK - 1) : CW'(TICKS_NORMAL - 1);
      end else if (pace_q != '0) begin
        pace_q <= pace_q - CW'(1);
      end
    end
  end

  assign bus.out_write = out_write_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.drop0     = drop_q[0];
  assign bus.drop1     = drop_q[1];
endmodule

// File: tb/tb_pointing_device_arbiter.sv
// Self-checking bench: a vector table drives both sources and checks drop
// pulses; expected emissions go to a scoreboard checked by a monitor.
module tb_pointing_device_arbiter;
  localparam int DEPTH = 4;
  localparam int TN    = 10;
  localparam int TO    = 7;

  typedef struct {
    bit         rts;
    bit         ovc;
    bit         w0;
    logic [7:0] d0;
    bit         w1;
    logic [7:0] d1;
    bit         dr0;
    bit         dr1;
    int         n_exp;
    int         idle_after;
    bit         drain;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    bit         s;
    int         off;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    bit         s;
    int         cyc;
  } sb_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   e_idx;
  vec_t vt  [$];
  exp_t et  [$];
  sb_t  sbq [$];
  sb_t  mon_item;

  pointing_device_arbiter_if bus ();

  pointing_device_arbiter #(
    .FIFO_DEPTH      (DEPTH),
    .TICKS_NORMAL    (TN),
    .TICKS_OVERCLOCK (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_write === 1'b1) begin
      if (sbq.size() == 0) begin
        check("spurious_write", {31'd0, bus.out_write}, 32'd0);
      end else begin
        mon_item = sbq.pop_front();
        check("out_data", {24'd0, bus.out_data}, {24'd0, mon_item.b});
        check("out_src", {31'd0, bus.out_src}, {31'd0, mon_item.s});
        check("out_cycle", cyc, mon_item.cyc);
      end
    end
  end

  task automatic add_v(input bit rts, input bit ovc, input bit w0, input logic [7:0] d0,
                       input bit w1, input logic [7:0] d1, input bit dr0, input bit dr1,
                       input int n_exp, input int idle_after, input bit drain);
    vec_t v;
    v.rts = rts; v.ovc = ovc; v.w0 = w0; v.d0 = d0; v.w1 = w1; v.d1 = d1;
    v.dr0 = dr0; v.dr1 = dr1; v.n_exp = n_exp; v.idle_after = idle_after; v.drain = drain;
    vt.push_back(v);
  endtask

  task automatic add_e(input logic [7:0] b, input bit s, input int off);
    exp_t e;
    e.b = b; e.s = s; e.off = off;
    et.push_back(e);
  endtask

  task automatic apply(input vec_t v);
    sb_t item;
    bus.rts       = v.rts;
    bus.overclock = v.ovc;
    bus.in0_write = v.w0;
    bus.in0_data  = v.d0;
    bus.in1_write = v.w1;
    bus.in1_data  = v.d1;
    @(negedge clk);
    bus.in0_write = 1'b0;
    bus.in1_write = 1'b0;
    bus.rts       = 1'b0;
    check("drop0", {31'd0, bus.drop0}, {31'd0, v.dr0});
    check("drop1", {31'd0, bus.drop1}, {31'd0, v.dr1});
    for (int k = 0; k < v.n_exp; k++) begin
      item.b   = et[e_idx].b;
      item.s   = et[e_idx].s;
      item.cyc = cyc + et[e_idx].off;
      sbq.push_back(item);
      e_idx++;
    end
  endtask

  task automatic idle(input int n);
    bus.in0_write = 1'b0;
    bus.in1_write = 1'b0;
    bus.rts       = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sbq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; e_idx = 0;
    reset = 1'b1;
    bus.rts = 1'b0; bus.overclock = 1'b0;
    bus.in0_write = 1'b0; bus.in0_data = 8'h00;
    bus.in1_write = 1'b0; bus.in1_data = 8'h00;

    // Two 3-byte packets complete together; source 0 wins the first tie.
    add_v(0,0, 1,8'hC1, 1,8'hE0, 0,0, 0,0,0);
    add_v(0,0, 1,8'h81, 1,8'h90, 0,0, 0,0,0);
    add_v(0,0, 1,8'h82, 1,8'hA0, 0,0, 6,0,1);
    add_e(8'hC1,0,1); add_e(8'h81,0,11); add_e(8'h82,0,21);
    add_e(8'hE0,1,31); add_e(8'h90,1,41); add_e(8'hA0,1,51);
    // Single device-ID byte, two-cycle latency.
    add_v(0,0, 1,8'hCA, 0,8'h00, 0,0, 1,0,1);
    add_e(8'hCA,0,1);
    // Last served 0: a tie now goes to source 1.
    add_v(0,0, 1,8'hCA, 1,8'hCA, 0,0, 2,0,1);
    add_e(8'hCA,1,1); add_e(8'hCA,0,11);
    // New start byte aborts an open packet.
    add_v(0,0, 1,8'hC1, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h81, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'hC2, 0,8'h00, 1,0, 0,0,0);
    add_v(0,0, 1,8'h83, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h84, 0,8'h00, 0,0, 3,0,1);
    add_e(8'hC2,0,1); add_e(8'h83,0,11); add_e(8'h84,0,21);
    // Malformed and stray continuation bytes; open packet survives a malformed byte.
    add_v(0,0, 0,8'h00, 1,8'h12, 0,1, 0,0,0);
    add_v(0,0, 0,8'h00, 1,8'h85, 0,1, 0,0,0);
    add_v(0,0, 1,8'hC4, 1,8'h7F, 0,1, 0,0,0);
    add_v(0,0, 1,8'h3F, 0,8'h00, 1,0, 0,0,0);
    add_v(0,0, 1,8'h94, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h95, 0,8'h00, 0,0, 3,0,1);
    add_e(8'hC4,0,1); add_e(8'h94,0,11); add_e(8'h95,0,21);
    // Overclock pacing.
    add_v(0,1, 0,8'h00, 1,8'hD0, 0,0, 0,0,0);
    add_v(0,1, 0,8'h00, 1,8'hA1, 0,0, 0,0,0);
    add_v(0,1, 0,8'h00, 1,8'hA2, 0,0, 3,0,1);
    add_e(8'hD0,1,1); add_e(8'hA1,1,8); add_e(8'hA2,1,15);
    // Pacing stalled with 3 committed bytes in a 4-deep FIFO: next packet dropped whole.
    add_v(0,0, 0,8'h00, 1,8'hCA, 0,0, 1,0,0);
    add_e(8'hCA,1,1);
    add_v(0,0, 1,8'hC3, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h87, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h88, 0,8'h00, 0,0, 3,0,0);
    add_e(8'hC3,0,8); add_e(8'h87,0,18); add_e(8'h88,0,28);
    add_v(0,0, 1,8'hC5, 0,8'h00, 1,0, 0,0,0);
    add_v(0,0, 1,8'h85, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h86, 0,8'h00, 0,0, 0,0,1);
    // Flush mid-packet: remainder abandoned, strobes ignored, pacing cleared.
    add_v(0,0, 1,8'hC7, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h97, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 1,8'h98, 0,8'h00, 0,0, 1,1,0);
    add_e(8'hC7,0,1);
    add_v(1,0, 1,8'hCA, 0,8'h00, 0,0, 0,0,0);
    add_v(1,0, 0,8'h00, 1,8'h12, 0,0, 0,0,0);
    add_v(1,0, 0,8'h00, 0,8'h00, 0,0, 0,0,0);
    add_v(0,0, 0,8'h00, 1,8'hCA, 0,0, 1,0,1);
    add_e(8'hCA,1,1);

    repeat (3) @(negedge clk);
    check("rst_out_write", {31'd0, bus.out_write}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_out_src", {31'd0, bus.out_src}, 32'd0);
    check("rst_drop0", {31'd0, bus.drop0}, 32'd0);
    check("rst_drop1", {31'd0, bus.drop1}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i]);
      if (vt[i].idle_after > 0) idle(vt[i].idle_after);
      if (vt[i].drain) begin
        drain(200);
        idle(12);
      end
    end

    idle(30);
    check("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
